sdf_stage_ctrl: RTL

Sequencing controller for one radix-2 single-delay-feedback (SDF) NTT stage: FIFO, butterfly, two 2:1 muxes and Montgomery multiplier. It replaces free-running counter sequencing with an explicit state machine. The state machine accepts a valid/ready sample stream and drives FIFO push/pop, both mux selects and the twiddle index. It qualifies multiplier output with a latency-matched valid and flushes the last frame without further input.

---
 rtl/sdf_stage_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencing FSM for one radix-2 SDF NTT stage (FIFO, butterfly, muxes, multiplier).
// Define SDF_CTRL_ERRCHK_EN to enable the protocol checker driving proto_err.
module sdf_stage_ctrl #(
    parameter int DELAY = 4,
    parameter int MUL_LAT = 1,
    parameter int TW_UNITY_IDX = 0,
    localparam int CW = $clog2(DELAY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          fifo_push,
    output logic          fifo_pop,
    output logic          sel_fb,
    output logic          sel_bf,
    output logic [CW-1:0] tw_index,
    output logic          out_valid,
    output logic          busy,
    output logic          proto_err
);
    typedef enum logic [2:0] {IDLE, FILL, BFLY, ROT, FLUSH} state_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DELAY - 1);
    localparam logic [CW-1:0] TW_UNITY = CW'(TW_UNITY_IDX);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [MUL_LAT-1:0] mul_sr;
    logic               acc;
    logic               last_cnt;

    assign in_ready  = state != FLUSH;
    assign acc       = in_valid & in_ready;
    assign last_cnt  = cnt == CNT_MAX;
    assign fifo_push = acc;
    assign fifo_pop  = state == FLUSH || (acc && (state == BFLY || state == ROT));
    assign sel_fb    = state == BFLY;
    assign sel_bf    = state == BFLY;
    assign tw_index  = state == BFLY ? TW_UNITY : (state == ROT || state == FLUSH) ? cnt : '0;
    assign out_valid = mul_sr[MUL_LAT-1];
    assign busy      = state != IDLE;

    // Every pop feeds the multiplier, so the pop strobe is the multiplier-input valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mul_sr <= '0;
        end else begin
            mul_sr <= MUL_LAT'({mul_sr, fifo_pop});
            case (state)
                IDLE: if (acc) begin
                    state <= FILL;
                    cnt   <= CW'(1);
                end
                FILL: if (acc) begin
                    state <= last_cnt ? BFLY : FILL;
                    cnt   <= last_cnt ? '0 : cnt + CW'(1);
                end
                BFLY: if (acc) begin
                    state <= last_cnt ? (in_last ? FLUSH : ROT) : BFLY;
                    cnt   <= last_cnt ? '0 : cnt + CW'(1);
                end
                ROT: if (acc) begin
                    state <= last_cnt ? BFLY : ROT;
                    cnt   <= last_cnt ? '0 : cnt + CW'(1);
                end
                FLUSH: begin
                    state <= last_cnt ? IDLE : FLUSH;
                    cnt   <= last_cnt ? '0 : cnt + CW'(1);
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SDF_CTRL_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= (acc && in_last && !(state == BFLY && last_cnt)) || (in_valid && state == FLUSH);
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif
endmodule
